// File: rtl/cc_if.sv
// Job request / coordinate-engine stream bundle shared by cc_host and its client.
interface cc_if;
   logic              start;
   logic [1:0]        job_mode;
   logic [31:0]       job_x;
   logic [31:0]       job_y;
   logic              busy;
   logic              cc_in_valid;
   logic [1:0]        cc_mode;
   logic [7:0]        cc_xi;
   logic [7:0]        cc_yi;
   logic              cc_out_valid;
   logic signed [7:0] cc_xo;
   logic signed [7:0] cc_yo;
   logic              done;
   logic              err;
   logic [15:0]       res_count;
   logic [15:0]       res_xsum;
   logic [15:0]       res_ysum;
   logic [15:0]       res_last;

   modport master (
      output start, job_mode, job_x, job_y, cc_out_valid, cc_xo, cc_yo,
      input  busy, cc_in_valid, cc_mode, cc_xi, cc_yi, done, err,
             res_count, res_xsum, res_ysum, res_last
   );

   modport slave (
      input  start, job_mode, job_x, job_y, cc_out_valid, cc_xo, cc_yo,
      output busy, cc_in_valid, cc_mode, cc_xi, cc_yi, done, err,
             res_count, res_xsum, res_ysum, res_last
   );
endinterface

// File: rtl/cc_host.sv
// Coordinate-engine host: serialises a 4-corner job, collects the result
// stream with a wait timeout, and keeps count/sum/last of received samples.
//
// state | meaning
// IDLE  | waiting for start; results and err hold
// SEND  | four beats UL, UR, LL, LR to the engine
// WAIT  | waiting for the first result, timeout counter running
// RECV  | accumulating results while cc_out_valid stays high
// DONE  | one-cycle done pulse, err set if WAIT timed out
module cc_host #(
   parameter int TIMEOUT = 255
) (
   input logic clk,
   input logic rst_n,
   cc_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   state_t      state_q, state_d;
   logic [1:0]  beat_q, beat_d;
   logic [15:0] wait_q, wait_d;
   logic [1:0]  mode_q, mode_d;
   logic [31:0] x_q, x_d;
   logic [31:0] y_q, y_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] xsum_q, xsum_d;
   logic [15:0] ysum_q, ysum_d;
   logic [15:0] last_q, last_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        in_valid_q, in_valid_d;
   logic [1:0]  cc_mode_q, cc_mode_d;
   logic [7:0]  xi_q, xi_d;
   logic [7:0]  yi_q, yi_d;
   logic        take;

   // State register plus all job, result and output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         beat_q     <= '0;
         wait_q     <= '0;
         mode_q     <= '0;
         x_q        <= '0;
         y_q        <= '0;
         cnt_q      <= '0;
         xsum_q     <= '0;
         ysum_q     <= '0;
         last_q     <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         in_valid_q <= 1'b0;
         cc_mode_q  <= '0;
         xi_q       <= '0;
         yi_q       <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         wait_q     <= wait_d;
         mode_q     <= mode_d;
         x_q        <= x_d;
         y_q        <= y_d;
         cnt_q      <= cnt_d;
         xsum_q     <= xsum_d;
         ysum_q     <= ysum_d;
         last_q     <= last_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         in_valid_q <= in_valid_d;
         cc_mode_q  <= cc_mode_d;
         xi_q       <= xi_d;
         yi_q       <= yi_d;
      end
   end

   // Next state, job latch, wait timer and result accumulation.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      wait_d  = wait_q;
      mode_d  = mode_q;
      x_d     = x_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      xsum_d  = xsum_q;
      ysum_d  = ysum_q;
      last_d  = last_q;
      err_d   = err_q;
      take    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_SEND;
               beat_d  = '0;
               mode_d  = bus.job_mode;
               x_d     = bus.job_x;
               y_d     = bus.job_y;
               cnt_d   = '0;
               xsum_d  = '0;
               ysum_d  = '0;
               last_d  = '0;
               err_d   = 1'b0;
            end
         end
         S_SEND: begin
            if (beat_q == 2'd3) begin
               state_d = S_WAIT;
               wait_d  = '0;
            end else begin
               beat_d = beat_q + 2'd1;
            end
         end
         S_WAIT: begin
            if (bus.cc_out_valid) begin
               state_d = S_RECV;
               take    = 1'b1;
            end else begin
               wait_d = wait_q + 16'd1;
               if (wait_d == TIMEOUT_C) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end
            end
         end
         S_RECV: begin
            if (bus.cc_out_valid) take = 1'b1;
            else                  state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (take) begin
         cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
         xsum_d = xsum_q + {{8{bus.cc_xo[7]}}, bus.cc_xo};
         ysum_d = ysum_q + {{8{bus.cc_yo[7]}}, bus.cc_yo};
         last_d = {bus.cc_xo, bus.cc_yo};
      end
   end

   // Registered outputs derived from the upcoming state so they align with it.
   always_comb begin
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      in_valid_d = (state_d == S_SEND);
      cc_mode_d  = '0;
      xi_d       = '0;
      yi_d       = '0;
      if (state_d == S_SEND) begin
         cc_mode_d = mode_d;
         xi_d      = x_d[{beat_d, 3'b000} +: 8];
         yi_d      = y_d[{beat_d, 3'b000} +: 8];
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
   assign bus.cc_in_valid = in_valid_q;
   assign bus.cc_mode     = cc_mode_q;
   assign bus.cc_xi       = xi_q;
   assign bus.cc_yi       = yi_q;
   assign bus.res_count   = cnt_q;
   assign bus.res_xsum    = xsum_q;
   assign bus.res_ysum    = ysum_q;
   assign bus.res_last    = last_q;
endmodule

// File: tb/tb_cc_host.sv
// Randomised bench for cc_host against a job-level reference model.
module tb_cc_host;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   logic signed [7:0] sx [16];
   logic signed [7:0] sy [16];

   cc_if bus ();
   cc_host #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, " busy"},  32'(bus.busy), 0);
      check_eq({tag, " done"},  32'(bus.done), 0);
      check_eq({tag, " err"},   32'(bus.err), 0);
      check_eq({tag, " inv"},   32'(bus.cc_in_valid), 0);
      check_eq({tag, " mode"},  32'(bus.cc_mode), 0);
      check_eq({tag, " xi"},    32'(bus.cc_xi), 0);
      check_eq({tag, " yi"},    32'(bus.cc_yi), 0);
      check_eq({tag, " cnt"},   32'(bus.res_count), 0);
      check_eq({tag, " xsum"},  32'(bus.res_xsum), 0);
      check_eq({tag, " ysum"},  32'(bus.res_ysum), 0);
      check_eq({tag, " last"},  32'(bus.res_last), 0);
   endtask

   // One complete job: d silent WAIT cycles then n samples from sx/sy
   // (index 0 reused past 16). rst_at >= 0 asserts reset after that sample.
   task automatic run_job(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                          input int d, input int n, input bit hold, input bit poke,
                          input int rst_at);
      logic [7:0] xb [4];
      logic [7:0] yb [4];
      int  cnt = 0;
      int  mx = 0;
      int  my = 0;
      logic [15:0] last = 0;
      bit  tmo;
      int  silent;
      int  idx;
      for (int b = 0; b < 4; b++) begin
         xb[b] = 8'((x >> (8 * b)) & 32'hFF);
         yb[b] = 8'((y >> (8 * b)) & 32'hFF);
      end
      bus.job_mode = m;
      bus.job_x    = x;
      bus.job_y    = y;
      bus.start    = 1'b1;
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      for (int b = 0; b < 4; b++) begin
         check_eq("send busy", 32'(bus.busy), 1);
         check_eq("send inv",  32'(bus.cc_in_valid), 1);
         check_eq("send xi",   32'(bus.cc_xi), 32'(xb[b]));
         check_eq("send yi",   32'(bus.cc_yi), 32'(yb[b]));
         check_eq("send mode", 32'(bus.cc_mode), 32'(m));
         if (poke && b == 1) begin
            bus.start = 1'b1;
            bus.job_x = ~x;
            bus.job_y = ~y;
         end
         if (poke && b == 2) bus.start = hold;
         @(negedge clk);
      end
      check_eq("post inv",  32'(bus.cc_in_valid), 0);
      check_eq("post xi",   32'(bus.cc_xi), 0);
      check_eq("post yi",   32'(bus.cc_yi), 0);
      check_eq("post mode", 32'(bus.cc_mode), 0);
      check_eq("post busy", 32'(bus.busy), 1);
      tmo    = (d >= TO);
      silent = tmo ? TO : d;
      for (int i = 0; i < silent; i++) begin
         bus.cc_out_valid = 1'b0;
         @(negedge clk);
         if (!tmo || i < silent - 1) check_eq("wait done", 32'(bus.done), 0);
      end
      if (!tmo) begin
         for (int i = 0; i < n; i++) begin
            idx = (i < 16) ? i : 0;
            bus.cc_out_valid = 1'b1;
            bus.cc_xo = sx[idx];
            bus.cc_yo = sy[idx];
            @(negedge clk);
            cnt  = (cnt < 65535) ? cnt + 1 : 65535;
            mx  += int'(sx[idx]);
            my  += int'(sy[idx]);
            last = {sx[idx], sy[idx]};
            if (i < 16) check_eq("recv done", 32'(bus.done), 0);
            if (i == rst_at) begin
               rst_n = 1'b0;
               #1;
               check_zero("midrst");
               bus.cc_out_valid = 1'b0;
               @(negedge clk);
               rst_n = 1'b1;
               @(negedge clk);
               return;
            end
         end
         bus.cc_out_valid = 1'b0;
         @(negedge clk);
      end
      check_eq("done",     32'(bus.done), 1);
      check_eq("err",      32'(bus.err), 32'(tmo));
      check_eq("cnt",      32'(bus.res_count), 32'(cnt));
      check_eq("xsum",     32'(bus.res_xsum), 32'(mx & 16'hFFFF));
      check_eq("ysum",     32'(bus.res_ysum), 32'(my & 16'hFFFF));
      check_eq("last",     32'(bus.res_last), 32'(last));
      @(negedge clk);
      check_eq("idle done", 32'(bus.done), 0);
      check_eq("idle busy", 32'(bus.busy), 0);
      check_eq("hold err",  32'(bus.err), 32'(tmo));
      check_eq("hold cnt",  32'(bus.res_count), 32'(cnt));
      check_eq("hold last", 32'(bus.res_last), 32'(last));
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.start        = 1'b0;
      bus.job_mode     = '0;
      bus.job_x        = '0;
      bus.job_y        = '0;
      bus.cc_out_valid = 1'b0;
      bus.cc_xo        = '0;
      bus.cc_yo        = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      sx[0] = 1;  sy[0] = 2;
      sx[1] = 3;  sy[1] = -4;
      sx[2] = 5;  sy[2] = 6;
      run_job(2'd2, 32'h04030201, 32'h08070605, 2, 3, 0, 0, -1);

      sx[0] = 0;  sy[0] = 2;
      run_job(2'd1, 32'h11223344, 32'h55667788, 0, 1, 0, 0, -1);

      run_job(2'd3, 32'hA5A5A5A5, 32'h5A5A5A5A, TO, 0, 0, 0, -1);

      sx[0] = -7; sy[0] = 9;
      run_job(2'd0, 32'hDEADBEEF, 32'hCAFEF00D, 3, 1, 0, 1, -1);

      sx[0] = 10; sy[0] = 20;
      sx[1] = 30; sy[1] = 40;
      sx[2] = 50; sy[2] = 60;
      run_job(2'd1, 32'h01020304, 32'h05060708, 1, 2, 1, 0, -1);
      run_job(2'd2, 32'h0A0B0C0D, 32'h0E0F1011, TO - 1, 3, 0, 0, -1);

      run_job(2'd3, 32'h12345678, 32'h9ABCDEF0, 1, 3, 0, 0, 1);
      run_job(2'd2, 32'h04030201, 32'h08070605, 0, 3, 0, 0, -1);

      sx[0] = 127; sy[0] = -128;
      run_job(2'd1, 32'h7F7F7F7F, 32'h80808080, 0, 70000, 0, 0, -1);

      for (int j = 0; j < 30; j++) begin
         for (int k = 0; k < 16; k++) begin
            sx[k] = 8'($urandom);
            sy[k] = 8'($urandom);
         end
         run_job(2'($urandom), $urandom, $urandom, $urandom_range(0, TO + 1),
                 $urandom_range(1, 16), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, -1);
      end
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("final idle", 32'(bus.busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
